// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM state encoding and
// the power-on baud compare value.
package uart_tx_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ISSUE    = 2'd1,
    ST_WAIT_ACK = 2'd2,
    ST_WAIT_REL = 2'd3
  } arb_state_e;

  localparam logic [15:0] UART_DEF_COMP = 16'd434;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Round-robin priority picker: returns the first valid requester at or after
// the pointer, wrapping modulo NREQ, as both a one-hot vector and an index.
module uart_tx_arbiter_rr_pick #(
  parameter int NREQ = 4,
  parameter int IDXW = 2
) (
  input  logic [NREQ-1:0] valid_i,
  input  logic [IDXW-1:0] ptr_i,
  output logic [NREQ-1:0] onehot_o,
  output logic [IDXW-1:0] idx_o,
  output logic            any_o
);

  logic [IDXW-1:0] cand;

  // Scan offsets from farthest to nearest so the nearest valid index wins
  always_comb begin
    idx_o    = '0;
    any_o    = 1'b0;
    cand     = '0;
    onehot_o = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = IDXW'((int'(ptr_i) + k) % NREQ);
      if (valid_i[cand]) begin
        idx_o = cand;
        any_o = 1'b1;
      end else begin
        any_o = any_o;
      end
    end
    onehot_o[idx_o] = any_o;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART transmitter between NREQ byte
// producers. Owns transmitter enable and baud compare, and flags a
// transmitter that never acknowledges.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int          NREQ     = 4,
  parameter int          IDXW     = 2,
  parameter logic [15:0] DEF_COMP = UART_DEF_COMP,
  parameter int          TO_W     = 20
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              cfg_we,
  input  logic [15:0]       cfg_comp,
  input  logic [NREQ-1:0]   rq_valid,
  input  logic [8*NREQ-1:0] rq_data,
  output logic [NREQ-1:0]   rq_ready,
  output logic              tx_en,
  output logic [15:0]       tx_comp,
  output logic [7:0]        tx_data,
  output logic              tx_req,
  input  logic              tx_ack,
  output logic              busy,
  output logic [IDXW-1:0]   grant_idx,
  output logic              err_timeout
);

  arb_state_e      state_q, state_d;
  logic [IDXW-1:0] ptr_q, ptr_d;
  logic [IDXW-1:0] grant_q, grant_d;
  logic [IDXW-1:0] pick_idx, ptr_next;
  logic [NREQ-1:0] pick_onehot;
  logic            pick_any, grant_ok;
  logic [15:0]     shadow_q, shadow_d;
  logic [15:0]     comp_q, comp_d;
  logic [7:0]      data_q, data_d;
  logic            tx_en_q;
  logic            req_q, req_d;
  logic            err_q, err_d;
  logic [TO_W-1:0] cnt_q, cnt_d, cnt_inc;

  uart_tx_arbiter_rr_pick #(
    .NREQ (NREQ),
    .IDXW (IDXW)
  ) u_rr_pick (
    .valid_i  (rq_valid),
    .ptr_i    (ptr_q),
    .onehot_o (pick_onehot),
    .idx_o    (pick_idx),
    .any_o    (pick_any)
  );

  // Requester after the last granted one; used when a byte completes or is abandoned
  assign ptr_next = (grant_q == IDXW'(NREQ - 1)) ? '0 : grant_q + 1'b1;
  assign cnt_inc  = cnt_q + 1'b1;

  // A grant only happens from IDLE with the transmitter already enabled
  assign grant_ok = !reset && enable && tx_en_q && (state_q == ST_IDLE) && pick_any;
  assign rq_ready = grant_ok ? pick_onehot : '0;

  // Next-state logic: handshake sequencing, timeout and configuration shadowing
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    grant_d  = grant_q;
    data_d   = data_q;
    req_d    = 1'b0;
    err_d    = err_q;
    cnt_d    = cnt_q;
    shadow_d = cfg_we ? cfg_comp : shadow_q;
    // Baud changes only reach the transmitter between bytes
    comp_d   = (state_q == ST_IDLE) ? shadow_d : comp_q;

    if (!enable) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (grant_ok) begin
            data_d  = rq_data[{pick_idx, 3'b000} +: 8];
            grant_d = pick_idx;
            req_d   = 1'b1;
            state_d = ST_ISSUE;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_ISSUE: begin
          cnt_d   = '0;
          state_d = ST_WAIT_ACK;
        end
        ST_WAIT_ACK: begin
          if (tx_ack) begin
            state_d = ST_WAIT_REL;
          end else if (cnt_inc == '1) begin
            // Give up on this byte; the next requester gets its turn
            err_d   = 1'b1;
            ptr_d   = ptr_next;
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        ST_WAIT_REL: begin
          if (!tx_ack) begin
            ptr_d   = ptr_next;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_WAIT_REL;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      ptr_q    <= '0;
      grant_q  <= '0;
      data_q   <= 8'd0;
      req_q    <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
      shadow_q <= DEF_COMP;
      comp_q   <= DEF_COMP;
      tx_en_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      grant_q  <= grant_d;
      data_q   <= data_d;
      req_q    <= req_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      comp_q   <= comp_d;
      tx_en_q  <= enable;
    end
  end

  assign tx_en       = tx_en_q;
  assign tx_comp     = comp_q;
  assign tx_data     = data_q;
  assign tx_req      = req_q;
  assign busy        = (state_q != ST_IDLE);
  assign grant_idx   = grant_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus a randomized run, every
// cycle compared against a cycle-stamped transaction model.
module tb_uart_tx_arbiter;

  localparam int          NREQ = 4;
  localparam int          IDXW = 2;
  localparam int          TO_W = 4;
  localparam int          TMO  = (1 << TO_W) - 1;
  localparam logic [15:0] DEFC = 16'd434;

  logic              clk = 1'b0;
  logic              reset, enable, cfg_we, tx_ack;
  logic [15:0]       cfg_comp;
  logic [NREQ-1:0]   rq_valid, rq_ready;
  logic [8*NREQ-1:0] rq_data;
  logic              tx_en, tx_req, busy, err_timeout;
  logic [15:0]       tx_comp;
  logic [7:0]        tx_data;
  logic [IDXW-1:0]   grant_idx;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NREQ (NREQ), .IDXW (IDXW), .DEF_COMP (DEFC), .TO_W (TO_W)
  ) dut (
    .clk (clk), .reset (reset), .enable (enable), .cfg_we (cfg_we),
    .cfg_comp (cfg_comp), .rq_valid (rq_valid), .rq_data (rq_data),
    .rq_ready (rq_ready), .tx_en (tx_en), .tx_comp (tx_comp),
    .tx_data (tx_data), .tx_req (tx_req), .tx_ack (tx_ack), .busy (busy),
    .grant_idx (grant_idx), .err_timeout (err_timeout)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // Stimulus state
  logic        n_reset, n_enable, n_cfg_we;
  logic [15:0] n_cfg_comp;
  logic [NREQ-1:0] pv;
  logic [7:0]  pbyte [NREQ];
  int          mode;       // 0 directed, 1 all producers always full, 2 random
  bit          nack_all;
  int          ack_start, ack_end;

  // Reference model state
  bit          m_known, m_inflight, m_ackseen, m_err, m_txen;
  int          m_ptr, m_last, m_issue;
  logic [7:0]  m_data;
  logic [15:0] m_comp, m_shadow;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic int rr_ref(input logic [NREQ-1:0] v, input int p);
    for (int k = 0; k < NREQ; k++) begin
      if (v[(p + k) % NREQ]) return (p + k) % NREQ;
    end
    return 0;
  endfunction

  task automatic apply_inputs();
    reset    = n_reset;
    enable   = n_enable;
    cfg_we   = n_cfg_we;
    cfg_comp = n_cfg_comp;
    rq_valid = pv;
    for (int k = 0; k < NREQ; k++) rq_data[8*k +: 8] = pbyte[k];
    tx_ack = (cyc >= ack_start) && (cyc < ack_end);
  endtask

  task automatic check_outputs();
    logic [NREQ-1:0] er;
    er = '0;
    if (!reset && !m_inflight && enable && m_txen && (|rq_valid)) er[rr_ref(rq_valid, m_ptr)] = 1'b1;
    chk("rq_ready",    rq_ready,    er);
    chk("tx_req",      tx_req,      m_inflight && (cyc == m_issue));
    chk("busy",        busy,        m_inflight);
    chk("tx_en",       tx_en,       m_txen);
    chk("tx_comp",     tx_comp,     m_comp);
    chk("tx_data",     tx_data,     m_data);
    chk("grant_idx",   grant_idx,   m_last);
    chk("err_timeout", err_timeout, m_err);
  endtask

  task automatic model_update();
    bit was_idle;
    int g;
    if (reset) begin
      m_known = 1; m_inflight = 0; m_ackseen = 0; m_err = 0; m_txen = 0;
      m_ptr = 0; m_last = 0; m_data = 8'd0; m_comp = DEFC; m_shadow = DEFC;
    end else begin
      was_idle = !m_inflight;
      if (cfg_we) m_shadow = cfg_comp;
      if (was_idle) m_comp = m_shadow;
      if (!enable) begin
        m_inflight = 0;
      end else if (was_idle) begin
        if (m_txen && (|rq_valid)) begin
          g = rr_ref(rq_valid, m_ptr);
          m_last = g; m_data = rq_data[8*g +: 8];
          m_inflight = 1; m_ackseen = 0; m_issue = cyc + 1;
        end
      end else if (cyc == m_issue) begin
        m_ackseen = 0;
      end else if (!m_ackseen) begin
        if (tx_ack) m_ackseen = 1;
        else if (cyc - m_issue == TMO) begin
          m_err = 1; m_inflight = 0; m_ptr = (m_last + 1) % NREQ;
        end
      end else if (!tx_ack) begin
        m_inflight = 0; m_ptr = (m_last + 1) % NREQ;
      end
      m_txen = enable;
    end
  endtask

  task automatic plan_next();
    for (int k = 0; k < NREQ; k++) begin
      if (rq_valid[k] && rq_ready[k]) begin
        pbyte[k] = 8'($urandom);
        if (mode != 1) pv[k] = 1'b0;
      end else if (mode == 2 && !pv[k] && ($urandom % 4 == 0)) begin
        pv[k] = 1'b1; pbyte[k] = 8'($urandom);
      end
    end
    if (tx_req) begin
      if (nack_all || (mode == 2 && $urandom % 8 == 0)) begin
        ack_start = 0; ack_end = 0;
      end else if (mode == 0) begin
        ack_start = cyc + 2; ack_end = ack_start + 1;
      end else begin
        ack_start = cyc + int'($urandom_range(1, 4));
        ack_end   = ack_start + int'($urandom_range(1, 3));
      end
    end
    if (mode == 2) begin
      n_reset    = (m_inflight && m_ackseen && ($urandom % 15 == 0)) || ($urandom % 400 == 0);
      n_enable   = !(($urandom % 40 == 0) || (m_inflight && !m_ackseen && ($urandom % 25 == 0)));
      n_cfg_we   = ($urandom % 20 == 0);
      n_cfg_comp = 16'($urandom);
    end else begin
      n_reset  = 1'b0;
      n_cfg_we = 1'b0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    apply_inputs();
    @(negedge clk);
    if (m_known) check_outputs();
    model_update();
    plan_next();
    cyc++;
  endtask

  task automatic do_reset();
    n_reset = 1'b1;
    step();
    n_reset = 1'b0;
  endtask

  initial begin
    n_reset = 1'b1; n_enable = 1'b0; n_cfg_we = 1'b0; n_cfg_comp = 16'd0;
    pv = '0; mode = 0; nack_all = 0; ack_start = 0; ack_end = 0; m_known = 0;
    for (int k = 0; k < NREQ; k++) pbyte[k] = 8'd0;
    m_inflight = 0; m_ackseen = 0; m_err = 0; m_txen = 0;
    m_ptr = 0; m_last = 0; m_issue = 0; m_data = 8'd0; m_comp = DEFC; m_shadow = DEFC;

    // Reset values, then a single requester
    repeat (3) step();
    n_reset = 1'b0;
    repeat (2) step();
    n_enable = 1'b1;
    pbyte[2] = 8'hA5; pv = 4'b0100;
    repeat (12) step();

    // All producers always full from pointer 0; baud write while busy
    do_reset();
    mode = 1; pv = '1;
    for (int k = 0; k < NREQ; k++) pbyte[k] = 8'($urandom);
    repeat (10) step();
    for (int i = 0; i < 20 && !m_inflight; i++) step();
    chk("wait_busy", m_inflight, 1'b1);
    n_cfg_we = 1'b1; n_cfg_comp = 16'h0010;
    repeat (40) step();

    // Transmitter that never acknowledges
    do_reset();
    mode = 0; nack_all = 1; pv = 4'b0011;
    repeat (45) step();

    // Enable dropped while waiting for the acknowledge
    pv = 4'b1000;
    for (int i = 0; i < 30 && !(m_inflight && cyc > m_issue); i++) step();
    chk("wait_ack_phase", m_inflight && cyc > m_issue, 1'b1);
    n_enable = 1'b0; pv = 4'b0001;
    repeat (3) step();
    n_enable = 1'b1; nack_all = 0;
    repeat (10) step();

    // Reset while the transmitter is releasing its acknowledge
    pv = 4'b0100; pbyte[2] = 8'h3C;
    for (int i = 0; i < 30 && !m_ackseen; i++) step();
    chk("wait_release", m_ackseen, 1'b1);
    do_reset();
    repeat (5) step();

    // Randomized traffic
    mode = 2;
    do_reset();
    repeat (2500) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
